// File: rtl/mmio_bus_bridge.sv
// mmio_bus_bridge: decodes one CPU MMIO request onto one of N_SLAVES channels, holds it until that slave acks, then pulses Ready.
// Unmapped requests answer one cycle later with Error; define BUS_TIMEOUT_EN to bound the Ack wait to TIMEOUT_CYCLES (Error on expiry).
module mmio_bus_bridge #(
    parameter int ADDR_LENGTH    = 32,
    parameter int DATA_LENGTH    = 32,
    parameter int N_SLAVES       = 4,
    parameter logic [N_SLAVES*ADDR_LENGTH-1:0] SLAVE_BASE =
        {32'h1003_0000, 32'h1002_0000, 32'h0040_0000, 32'h1001_0000},
    parameter logic [N_SLAVES*ADDR_LENGTH-1:0] SLAVE_MASK =
        {32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFF0_0000, 32'hFFFF_0000},
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            MemRead,
    input  logic                            MemWrite,
    input  logic [ADDR_LENGTH-1:0]          AddrIn,
    input  logic [DATA_LENGTH-1:0]          DataIn,
    output logic [DATA_LENGTH-1:0]          DataOut,
    output logic                            Ready,
    output logic                            Error,
    output logic [ADDR_LENGTH-1:0]          AddrOut,
    output logic [DATA_LENGTH-1:0]          WDataOut,
    output logic [N_SLAVES-1:0]             Select,
    output logic                            Write,
    input  logic [N_SLAVES*DATA_LENGTH-1:0] RDataIn,
    input  logic [N_SLAVES-1:0]             Ack
);

    localparam int IDX_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

    if (N_SLAVES < 1 || N_SLAVES > 8 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_param
        $error("mmio_bus_bridge: N_SLAVES or TIMEOUT_CYCLES out of range");
    end

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                  state_q;
    logic [ADDR_LENGTH-1:0]  addr_q;
    logic [DATA_LENGTH-1:0]  wdata_q;
    logic [DATA_LENGTH-1:0]  dout_q;
    logic [N_SLAVES-1:0]     sel_q;
    logic [IDX_W-1:0]        idx_q;
    logic                    write_q;
    logic                    ready_q;
    logic                    error_q;

    logic                    dec_hit;
    logic [IDX_W-1:0]        dec_idx;
    logic [N_SLAVES-1:0]     dec_oh;
    logic                    ack_sel;
    logic [DATA_LENGTH-1:0]  rdata_sel;
    logic                    tmo_expire;

    // Scan from the top so the lowest matching index is the one left standing.
    always_comb begin
        dec_hit = 1'b0;
        dec_idx = '0;
        dec_oh  = '0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if ((AddrIn & SLAVE_MASK[i*ADDR_LENGTH +: ADDR_LENGTH]) ==
                SLAVE_BASE[i*ADDR_LENGTH +: ADDR_LENGTH]) begin
                dec_hit    = 1'b1;
                dec_idx    = IDX_W'(i);
                dec_oh     = '0;
                dec_oh[i]  = 1'b1;
            end
        end
    end

    assign ack_sel   = Ack[idx_q];
    assign rdata_sel = RDataIn[int'(idx_q)*DATA_LENGTH +: DATA_LENGTH];

`ifdef BUS_TIMEOUT_EN
    logic [7:0] tmo_cnt_q;
    assign tmo_expire = (tmo_cnt_q == 8'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_expire = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            dout_q    <= '0;
            sel_q     <= '0;
            idx_q     <= '0;
            write_q   <= 1'b0;
            ready_q   <= 1'b0;
            error_q   <= 1'b0;
`ifdef BUS_TIMEOUT_EN
            tmo_cnt_q <= '0;
`endif
        end else begin
            ready_q <= 1'b0;
            error_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (MemRead || MemWrite) begin
                        if (dec_hit) begin
                            state_q   <= ACCESS;
                            addr_q    <= AddrIn;
                            wdata_q   <= DataIn;
                            write_q   <= MemWrite;
                            sel_q     <= dec_oh;
                            idx_q     <= dec_idx;
`ifdef BUS_TIMEOUT_EN
                            tmo_cnt_q <= '0;
`endif
                        end else begin
                            state_q <= RESP;
                            ready_q <= 1'b1;
                            error_q <= 1'b1;
                            dout_q  <= '0;
                        end
                    end
                end
                ACCESS: begin
                    // Ack is checked before expiry so a last-cycle Ack still completes cleanly.
                    if (ack_sel) begin
                        if (!write_q) begin
                            dout_q <= rdata_sel;
                        end
                        state_q <= RESP;
                        ready_q <= 1'b1;
                        sel_q   <= '0;
                        write_q <= 1'b0;
                    end else if (tmo_expire) begin
                        state_q <= RESP;
                        ready_q <= 1'b1;
                        error_q <= 1'b1;
                        sel_q   <= '0;
                        write_q <= 1'b0;
                    end else begin
`ifdef BUS_TIMEOUT_EN
                        tmo_cnt_q <= tmo_cnt_q + 8'd1;
`endif
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign DataOut  = dout_q;
    assign Ready    = ready_q;
    assign Error    = error_q;
    assign AddrOut  = addr_q;
    assign WDataOut = wdata_q;
    assign Select   = sel_q;
    assign Write    = write_q;

endmodule

// File: tb/tb_mmio_bus_bridge.sv
// Directed bench for mmio_bus_bridge with default parameters; also covers the BUS_TIMEOUT_EN build.
module tb_mmio_bus_bridge;

    logic         clk;
    logic         rst;
    logic         MemRead;
    logic         MemWrite;
    logic [31:0]  AddrIn;
    logic [31:0]  DataIn;
    logic [31:0]  DataOut;
    logic         Ready;
    logic         Error;
    logic [31:0]  AddrOut;
    logic [31:0]  WDataOut;
    logic [3:0]   Select;
    logic         Write;
    logic [127:0] RDataIn;
    logic [3:0]   Ack;

    int checks   = 0;
    int failures = 0;

    mmio_bus_bridge dut (
        .clk      (clk),
        .rst      (rst),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .AddrIn   (AddrIn),
        .DataIn   (DataIn),
        .DataOut  (DataOut),
        .Ready    (Ready),
        .Error    (Error),
        .AddrOut  (AddrOut),
        .WDataOut (WDataOut),
        .Select   (Select),
        .Write    (Write),
        .RDataIn  (RDataIn),
        .Ack      (Ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         rd;
        logic         wr;
        logic [31:0]  addr;
        logic [31:0]  wdata;
        logic [127:0] rdata;
        int           ack_at;     // ACCESS cycle carrying the real Ack (0: none)
        logic [3:0]   ack_vec;
        logic [3:0]   spur_vec;   // Ack value driven in the ACCESS cycles before ack_at
        logic [3:0]   exp_sel;
        logic         exp_wr;
        logic         exp_err;
        logic [31:0]  exp_dout;
        int           exp_cycles;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [127:0] rdata,
                                input int ack_at, input logic [3:0] ack_vec, input logic [3:0] spur_vec,
                                input logic [3:0] exp_sel, input logic exp_wr, input logic exp_err,
                                input logic [31:0] exp_dout, input int exp_cycles);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
        v.ack_at = ack_at; v.ack_vec = ack_vec; v.spur_vec = spur_vec;
        v.exp_sel = exp_sel; v.exp_wr = exp_wr; v.exp_err = exp_err;
        v.exp_dout = exp_dout; v.exp_cycles = exp_cycles;
        return v;
    endfunction

    // Called right after a negedge with the bridge idle; returns right after a negedge, idle again.
    task automatic run_vec(input vec_t v, input string nm);
        int  cyc;
        bit  done;
        MemRead  = v.rd;
        MemWrite = v.wr;
        AddrIn   = v.addr;
        DataIn   = v.wdata;
        RDataIn  = v.rdata;
        Ack      = '0;
        @(negedge clk);
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        cyc  = 0;
        done = 1'b0;
        for (int t = 0; t < 64 && !done; t++) begin
            if (Ready === 1'b1) begin
                done = 1'b1;
            end else begin
                cyc++;
                chk({nm, " Select"},   Select,   v.exp_sel);
                chk({nm, " Write"},    Write,    v.exp_wr);
                chk({nm, " AddrOut"},  AddrOut,  v.addr);
                chk({nm, " WDataOut"}, WDataOut, v.wdata);
                if (cyc == v.ack_at)     Ack = v.ack_vec;
                else if (cyc < v.ack_at) Ack = v.spur_vec;
                else                     Ack = '0;
                @(negedge clk);
            end
        end
        Ack = '0;
        chk({nm, " completed"},     done,    1'b1);
        chk({nm, " access cycles"}, cyc,     v.exp_cycles);
        chk({nm, " Error"},         Error,   v.exp_err);
        chk({nm, " DataOut"},       DataOut, v.exp_dout);
        chk({nm, " Select in RESP"}, {Select, Write}, 5'b0);
        @(negedge clk);
        chk({nm, " Ready one cycle"}, Ready, 1'b0);
    endtask

    initial begin
        logic [6:0] exp_rdy;

        rst      = 1'b1;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        AddrIn   = '0;
        DataIn   = '0;
        RDataIn  = '0;
        Ack      = '0;

        vecs[0] = mk(1, 0, 32'h1001_0004, 32'h0, {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'hCAFE_F00D},
                     1, 4'b0001, 4'b0000, 4'b0001, 0, 0, 32'hCAFE_F00D, 1);
        vecs[1] = mk(0, 1, 32'h1002_0008, 32'h0000_00A5, {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_0000},
                     3, 4'b0100, 4'b0000, 4'b0100, 1, 0, 32'hCAFE_F00D, 3);
        vecs[2] = mk(1, 0, 32'h2000_0000, 32'h0, {4{32'hFFFF_FFFF}},
                     0, 4'b0000, 4'b1111, 4'b0000, 0, 1, 32'h0, 0);
        vecs[3] = mk(1, 0, 32'h004A_BC00, 32'h0, {32'h3333_3333, 32'h2222_2222, 32'h1234_5678, 32'h0000_0001},
                     2, 4'b0010, 4'b1101, 4'b0010, 0, 0, 32'h1234_5678, 2);
        vecs[4] = mk(1, 0, 32'h1003_000C, 32'h0, {32'hDEAD_BEEF, 32'h2222_2222, 32'h1111_1111, 32'h0000_0000},
                     1, 4'b1000, 4'b0000, 4'b1000, 0, 0, 32'hDEAD_BEEF, 1);
        vecs[5] = mk(1, 1, 32'h1001_0000, 32'h5555_AAAA, {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0BAD_0BAD},
                     3, 4'b0001, 4'b0010, 4'b0001, 1, 0, 32'hDEAD_BEEF, 3);
        vecs[6] = mk(0, 1, 32'h1003_0010, 32'h1234_0000, {4{32'hFFFF_FFFF}},
                     0, 4'b0000, 4'b0000, 4'b0000, 0, 1, 32'h0, 0);
        vecs[7] = mk(1, 0, 32'h1001_0000, 32'h0, {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'hA5A5_0F0F},
                     1, 4'b0001, 4'b0000, 4'b0001, 0, 0, 32'hA5A5_0F0F, 1);
        vecs[8] = mk(1, 0, 32'h1003_0004, 32'h0, {32'h600D_0016, 32'h2222_2222, 32'h1111_1111, 32'h0000_0000},
                     16, 4'b1000, 4'b0000, 4'b1000, 0, 0, 32'h600D_0016, 16);

        repeat (2) @(negedge clk);
        chk("reset outputs", {Select, Write, Ready, Error, DataOut, AddrOut, WDataOut}, '0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle after reset", {Select, Write, Ready}, '0);

        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Request held through RESP: Ready every third cycle, Ack outside ACCESS ignored.
        exp_rdy  = 7'b0010010;
        MemRead  = 1'b1;
        AddrIn   = 32'h1001_0000;
        RDataIn  = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h1111_2222};
        Ack      = 4'b0001;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            chk($sformatf("b2b Ready c%0d", i), Ready, exp_rdy[i]);
        end
        MemRead = 1'b0;
        repeat (2) @(negedge clk);
        Ack = '0;
        chk("b2b DataOut", DataOut, 32'h1111_2222);
        @(negedge clk);

        // Reset during the second ACCESS cycle of a write.
        MemWrite = 1'b1;
        AddrIn   = 32'h1002_0004;
        DataIn   = 32'h0000_0077;
        @(negedge clk);
        MemWrite = 1'b0;
        @(negedge clk);
        chk("abort pre Select", {Select, Write}, 5'b0100_1);
        #2 rst = 1'b1;
        #1;
        chk("abort Select/Write", {Select, Write}, 5'b0);
        chk("abort regs", {Ready, Error, DataOut, AddrOut, WDataOut}, '0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("abort no Ready c%0d", i), Ready, 1'b0);
        end
        run_vec(mk(1, 0, 32'h0040_0000, 32'h0, {32'h3333_3333, 32'h2222_2222, 32'h0BAD_CAFE, 32'h0},
                   1, 4'b0010, 4'b0000, 4'b0010, 0, 0, 32'h0BAD_CAFE, 1), "post-reset read");

        // Ack withheld on slave 3.
        MemRead = 1'b1;
        AddrIn  = 32'h1003_0000;
        RDataIn = {4{32'hEEEE_EEEE}};
        Ack     = '0;
        @(negedge clk);
        MemRead = 1'b0;
`ifdef BUS_TIMEOUT_EN
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("tmo Select c%0d", i), {Select, Ready}, 5'b1000_0);
            @(negedge clk);
        end
        chk("tmo Ready", Ready, 1'b1);
        chk("tmo Error", Error, 1'b1);
        chk("tmo DataOut", DataOut, 32'h0BAD_CAFE);
        @(negedge clk);
        chk("tmo Ready one cycle", {Ready, Select}, 5'b0);
`else
        for (int i = 0; i < 40; i++) begin
            chk($sformatf("hang Select c%0d", i), {Select, Ready}, 5'b1000_0);
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("hang cleared", {Select, Ready}, 5'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
